// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial port: transmit FSM encoding, baud phase
// positions for bit boundaries and receive sampling, and frame width.
package serial_port_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_t;

    // Bit boundaries sit on phase 0 so the receiver's phase-2 sample is mid-bit.
    localparam logic [1:0] BIT_PHASE_TX = 2'h0;
    localparam logic [1:0] BIT_PHASE_RX = 2'h2;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/serial_port_tx_if.sv
// Host-side write/status bundle of the serial port transmitter.
interface serial_port_tx_if;

    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_ovf;
    logic       tx_busy;
    logic       tx_done;

    // Host: writes bytes and watches status.
    modport master (
        output tx_data, tx_wr,
        input  tx_full, tx_ovf, tx_busy, tx_done
    );

    // Transmitter: accepts bytes and reports status.
    modport slave (
        input  tx_data, tx_wr,
        output tx_full, tx_ovf, tx_busy, tx_done
    );

endinterface

// File: rtl/serial_port_tx_fifo.sv
// Small synchronous FIFO for queued transmit bytes; head is visible on rdata.
module serial_port_tx_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Writes while full are dropped; the caller reports the overflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write.
    // NOTE: the data array carries no reset; only pointers and count define
    // validity, which keeps the array as plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Count never exceeds DEPTH (a power of two), so its MSB alone means full.
    assign full  = count[ADDR_W];
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/serial_port_tx.sv
// Serial port transmitter: queues host bytes and sends them as 8N1 frames,
// with every line change aligned to the baud generator's phase-0 advance.
import serial_port_pkg::*;

module serial_port_tx #(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       phase,
    input  logic             change,
    serial_port_tx_if.slave  host,
    output logic             tx
);

    localparam int CNT_W = $clog2(DATA_BITS);

    logic              tick;
    logic              fifo_pop;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;

    tx_state_t         state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q;

    assign tick = (phase == BIT_PHASE_TX) && change;

    serial_port_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.tx_wr),
        .pop   (fifo_pop),
        .wdata (host.tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and next-output logic; everything only moves on a tick.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        if (tick) begin
            case (state_q)
                TX_IDLE: begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = TX_START;
                    end
                end
                TX_START: begin
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        tx_d  = shift_q[cnt_q + CNT_W'(1)];
                    end
                end
                TX_STOP: begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        // Next frame starts immediately: no idle bit between.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        state_d  = TX_START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = TX_IDLE;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    // FSM state and registered line/status outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Overflow flag: a write seen while full was dropped by the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= host.tx_wr && fifo_full;
        end
    end

    // Empty flag and occupancy count must always agree.
    assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty == (fifo_count == '0));

    assign tx           = tx_q;
    assign host.tx_full = fifo_full;
    assign host.tx_ovf  = ovf_q;
    assign host.tx_busy = busy_q;
    assign host.tx_done = done_q;

endmodule

// File: tb/tb_serial_port_tx.sv
// Bench for serial_port_tx: directed frames plus a decoding line monitor that
// checks each received byte against a queue of expected bytes.
module tb_serial_port_tx;
    import serial_port_pkg::*;

    localparam int DEPTH    = 4;
    localparam int DIV      = 4;        // clks per baud phase
    localparam int BIT_CLKS = 4 * DIV;  // clks per bit period

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] phase  = 2'd0;
    logic       change = 1'b0;
    logic       tx;
    int         div_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ovf_cnt  = 0;
    int rx_cnt   = 0;
    int low_cnt  = 0;

    logic [7:0] exp_q [$];

    serial_port_tx_if host_if ();

    serial_port_tx #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .phase  (phase),
        .change (change),
        .host   (host_if),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    // Free-running baud generator: change pulses on the first clk of each phase.
    always @(posedge clk) begin
        if (div_cnt == DIV - 1) begin
            div_cnt <= 0;
            phase   <= phase + 2'd1;
            change  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            change  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Receive-side monitor: samples at phase 2, decodes 8N1, compares bytes.
    logic [1:0] mon_state = 2'd0;
    logic [3:0] mon_bit   = 4'd0;
    logic [7:0] mon_byte  = 8'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_state = 2'd0;
            exp_q.delete();
        end else begin
            if (host_if.tx_done) done_cnt++;
            if (host_if.tx_ovf)  ovf_cnt++;
            if (!tx)             low_cnt++;
            if (phase == BIT_PHASE_RX && change) begin
                case (mon_state)
                    2'd0: if (!tx) begin
                        mon_state = 2'd1;
                        mon_bit   = 4'd0;
                    end
                    2'd1: begin
                        mon_byte[mon_bit[2:0]] = tx;
                        mon_bit = mon_bit + 4'd1;
                        if (mon_bit == 4'd8) mon_state = 2'd2;
                    end
                    default: begin
                        mon_state = 2'd0;
                        rx_cnt++;
                        check("stop_bit", tx, 1);
                        check("rx_expected_pending", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
                    end
                endcase
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit accept);
        @(negedge clk);
        host_if.tx_wr   = 1'b1;
        host_if.tx_data = d;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic write_end();
        @(negedge clk);
        host_if.tx_wr = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (host_if.tx_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, host_if.tx_busy, lvl);
    endtask

    // Collect n consecutive phase-2 line samples, bit i = i-th sample.
    task automatic capture(input int n, output logic [31:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            do @(negedge clk); while (!(phase == BIT_PHASE_RX && change));
            bits[i] = tx;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bits;
        int          d0, o0, l0, r0, n;
        logic [7:0]  b;

        host_if.tx_wr   = 1'b0;
        host_if.tx_data = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx",   tx, 1);
        check("reset_busy", host_if.tx_busy, 0);
        check("reset_full", host_if.tx_full, 0);
        check("reset_done", host_if.tx_done, 0);
        check("reset_ovf",  host_if.tx_ovf, 0);
        rst_n = 1'b1;

        // Single frame 0xA5
        d0 = done_cnt;
        write_byte(8'hA5, 1'b1);
        write_end();
        wait_busy(1'b1, 3 * BIT_CLKS, "a5_busy_rise");
        capture(10, bits);
        check("a5_frame_bits", bits[9:0], 10'b1101001010);
        n = 0;
        while (!host_if.tx_done && n < 2 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("a5_done_pulse", host_if.tx_done, 1);
        check("a5_busy_falls_with_done", host_if.tx_busy, 0);
        @(negedge clk);
        check("a5_done_one_clk", host_if.tx_done, 0);
        check("a5_done_count", done_cnt - d0, 1);

        // Back-to-back 0x00, 0xFF
        d0 = done_cnt;
        write_byte(8'h00, 1'b1);
        write_byte(8'hFF, 1'b1);
        write_end();
        wait_busy(1'b1, 3 * BIT_CLKS, "b2b_busy_rise");
        capture(20, bits);
        check("b2b_frame_bits", bits[19:0], 20'b1111111110_1000000000);
        wait_busy(1'b0, 3 * BIT_CLKS, "b2b_busy_fall");
        @(negedge clk);
        check("b2b_done_count", done_cnt - d0, 2);

        // Overflow while 0x11 is on the line
        o0 = ovf_cnt;
        write_byte(8'h11, 1'b1);
        write_end();
        wait_busy(1'b1, 3 * BIT_CLKS, "ovf_busy_rise");
        write_byte(8'h12, 1'b1);
        write_byte(8'h13, 1'b1);
        write_byte(8'h14, 1'b1);
        write_byte(8'h15, 1'b1);
        check("ovf_not_full_before_4th", host_if.tx_full, 0);
        write_byte(8'h16, 1'b0);
        check("ovf_full_after_4th", host_if.tx_full, 1);
        @(negedge clk);
        check("ovf_pulse", host_if.tx_ovf, 1);
        host_if.tx_wr = 1'b0;
        @(negedge clk);
        check("ovf_pulse_one_clk", host_if.tx_ovf, 0);
        wait_busy(1'b0, 6 * 10 * BIT_CLKS, "ovf_busy_fall");
        @(negedge clk);
        check("ovf_count", ovf_cnt - o0, 1);
        check("ovf_queue_drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0x3C with two bytes queued
        write_byte(8'h3C, 1'b1);
        write_byte(8'h5A, 1'b1);
        write_byte(8'h96, 1'b1);
        write_end();
        wait_busy(1'b1, 3 * BIT_CLKS, "rst_busy_rise");
        capture(5, bits);
        check("rst_bits_to_d3", bits[4:0], 5'b11000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_idle", tx, 1);
        check("rst_busy_clear", host_if.tx_busy, 0);
        check("rst_full_clear", host_if.tx_full, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        l0 = low_cnt;
        repeat (5 * BIT_CLKS) @(negedge clk);
        check("rst_line_stays_idle", low_cnt - l0, 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_stays_not_busy", host_if.tx_busy, 0);

        // Loopback: 256 random bytes through the monitor
        r0 = rx_cnt;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            n = 0;
            @(negedge clk);
            while (host_if.tx_full && n < 20 * BIT_CLKS) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20 * BIT_CLKS) check("loop_full_timeout", host_if.tx_full, 0);
            host_if.tx_wr   = 1'b1;
            host_if.tx_data = b;
            exp_q.push_back(b);
            @(negedge clk);
            host_if.tx_wr = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 6 * 10 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        wait_busy(1'b0, 3 * BIT_CLKS, "loop_busy_fall");
        @(negedge clk);
        check("loop_queue_empty", exp_q.size(), 0);
        check("loop_rx_count", rx_cnt - r0, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
